// File: rtl/reg_write_queue.sv
// Dual-port posted-write queue feeding a 16 x 32-bit register bank; commits up to two writes per EN cycle.
// Optional zero-latency bypass when the queue is empty: define REG_WRITE_BYPASS_EN.
module reg_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         EN,
    input  logic         wa_valid,
    input  logic [3:0]   wa_addr,
    input  logic [31:0]  wa_data,
    output logic         wa_ready,
    input  logic         wb_valid,
    input  logic [3:0]   wb_addr,
    input  logic [31:0]  wb_data,
    output logic         wb_ready,
    output logic [511:0] bank_D,
    output logic [15:0]  bank_hold,
    output logic [4:0]   pending
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [3:0]    fifo_addr_q [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [4:0]    count_q, count_d;

    logic          a_acc, b_acc, bypass;
    logic          enq_a, enq_b;
    logic          commit0, commit1;
    logic [1:0]    enq_n, pop_n;
    logic [PW-1:0] head1_ptr, wr_slot_b;
    logic [3:0]    head0_addr, head1_addr;
    logic [31:0]   head0_data, head1_data;

    // Pointer advance modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [5:0] s;
        s = 6'(p) + 6'(n);
        if (s >= 6'(DEPTH))
            s = s - 6'(DEPTH);
        return s[PW-1:0];
    endfunction

    assign wa_ready = !Reset && (count_q < DEPTH_C);
    assign wb_ready = !Reset && ((count_q + 5'd1) < DEPTH_C);
    assign pending  = count_q;

    always_comb begin
        a_acc  = wa_valid && wa_ready;
        b_acc  = wb_valid && wb_ready;
`ifdef REG_WRITE_BYPASS_EN
        bypass = EN && !Reset && (count_q == 5'd0);
`else
        bypass = 1'b0;
`endif
        enq_a      = a_acc && !bypass;
        enq_b      = b_acc && !bypass;
        commit0    = EN && !Reset && (count_q != 5'd0);
        commit1    = EN && !Reset && (count_q >= 5'd2);
        enq_n      = {1'b0, enq_a} + {1'b0, enq_b};
        pop_n      = {1'b0, commit0} + {1'b0, commit1};
        head1_ptr  = ptr_add(rd_ptr_q, 2'd1);
        wr_slot_b  = enq_a ? ptr_add(wr_ptr_q, 2'd1) : wr_ptr_q;
        head0_addr = fifo_addr_q[rd_ptr_q];
        head0_data = fifo_data_q[rd_ptr_q];
        head1_addr = fifo_addr_q[head1_ptr];
        head1_data = fifo_data_q[head1_ptr];
        rd_ptr_d   = ptr_add(rd_ptr_q, pop_n);
        wr_ptr_d   = ptr_add(wr_ptr_q, enq_n);
        count_d    = count_q + 5'(enq_n) - 5'(pop_n);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked solely by count_q.
    always_ff @(posedge CLK) begin
        if (enq_a) begin
            fifo_addr_q[wr_ptr_q] <= wa_addr;
            fifo_data_q[wr_ptr_q] <= wa_data;
        end
        if (enq_b) begin
            fifo_addr_q[wr_slot_b] <= wb_addr;
            fifo_data_q[wr_slot_b] <= wb_data;
        end
    end

    // Per-register drive; priority runs youngest first so the younger write wins a collision.
    for (genvar gi = 0; gi < 16; gi++) begin : g_reg
        logic sel0, sel1, sel_a, sel_b;
        assign sel0  = commit0 && (head0_addr == 4'(gi));
        assign sel1  = commit1 && (head1_addr == 4'(gi));
        assign sel_a = bypass && a_acc && (wa_addr == 4'(gi));
        assign sel_b = bypass && b_acc && (wb_addr == 4'(gi));
        assign bank_hold[gi] = !(sel0 || sel1 || sel_a || sel_b);
        assign bank_D[32*gi +: 32] = sel_b ? wb_data :
                                     sel_a ? wa_data :
                                     sel1  ? head1_data :
                                     sel0  ? head0_data : 32'd0;
    end
endmodule

// File: tb/tb_reg_write_queue.sv
// Scoreboard bench for reg_write_queue: a queue-of-writes reference model predicts every cycle's outputs.
module tb_reg_write_queue;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         Reset = 1'b1;
    logic         EN = 1'b0;
    logic         wa_valid = 1'b0, wb_valid = 1'b0;
    logic [3:0]   wa_addr = '0, wb_addr = '0;
    logic [31:0]  wa_data = '0, wb_data = '0;
    logic         wa_ready, wb_ready;
    logic [511:0] bank_D;
    logic [15:0]  bank_hold;
    logic [4:0]   pending;

    reg_write_queue #(.DEPTH(DEPTH)) dut (
        .CLK(clk), .Reset(Reset), .EN(EN),
        .wa_valid(wa_valid), .wa_addr(wa_addr), .wa_data(wa_data), .wa_ready(wa_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .bank_D(bank_D), .bank_hold(bank_hold), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ra;
        logic         rb;
        logic [4:0]   pend;
        logic [15:0]  hold;
        logic [511:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [35:0] mq[$];     // pending writes {addr, data}, oldest first
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    // One cycle: drive inputs, predict this cycle's outputs, then advance the model at the edge.
    task automatic drive_cycle(input logic rst, input logic en,
                               input logic av, input logic [3:0] aa, input logic [31:0] ad,
                               input logic bv, input logic [3:0] ba, input logic [31:0] bd);
        exp_t        e;
        logic [35:0] commits[$];
        logic        byp, a_acc, b_acc;
        int          sz;
        @(negedge clk);
        Reset = rst; EN = en;
        wa_valid = av; wa_addr = aa; wa_data = ad;
        wb_valid = bv; wb_addr = ba; wb_data = bd;
        sz = mq.size();
        e.ra   = !rst && (sz <= DEPTH - 1);
        e.rb   = !rst && (sz <= DEPTH - 2);
        e.pend = 5'(sz);
        a_acc  = av && e.ra;
        b_acc  = bv && e.rb;
        byp    = 1'b0;
`ifdef REG_WRITE_BYPASS_EN
        byp = !rst && en && (sz == 0);
`endif
        if (!rst && en) begin
            if (byp) begin
                if (a_acc) commits.push_back({aa, ad});
                if (b_acc) commits.push_back({ba, bd});
            end else begin
                for (int i = 0; i < sz && i < 2; i++) commits.push_back(mq[i]);
            end
        end
        e.hold = '1;
        e.d    = '0;
        foreach (commits[i]) begin
            e.hold[commits[i][35:32]] = 1'b0;
            e.d[32*int'(commits[i][35:32]) +: 32] = commits[i][31:0];
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else if (!byp) begin
            repeat (commits.size()) void'(mq.pop_front());
            if (a_acc) mq.push_back({aa, ad});
            if (b_acc) mq.push_back({ba, bd});
        end
    endtask

    task automatic idle(input logic en);
        drive_cycle(1'b0, en, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wa_ready", 512'(wa_ready), 512'(e.ra));
                chk("wb_ready", 512'(wb_ready), 512'(e.rb));
                chk("pending", 512'(pending), 512'(e.pend));
                chk("bank_hold", 512'(bank_hold), 512'(e.hold));
                chk("bank_D", bank_D, e.d);
            end
        end
    end

    initial begin : stimulus
        logic        rst, en, av, bv;
        logic [3:0]  aa, ba;
        logic [31:0] ad, bd;
        drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        drive_cycle(1'b1, 1'b1, 1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2);
        // Single write, then its commit
        drive_cycle(1'b0, 1'b1, 1'b1, 4'd3, 32'h1234_5678, 1'b0, 4'd0, 32'd0);
        idle(1'b1); idle(1'b1);
        // Two different registers on one edge
        drive_cycle(1'b0, 1'b1, 1'b1, 4'd5, 32'hAAAA_AAAA, 1'b1, 4'd9, 32'h5555_5555);
        idle(1'b1); idle(1'b1);
        // Same register on both ports
        drive_cycle(1'b0, 1'b1, 1'b1, 4'd7, 32'h1111_1111, 1'b1, 4'd7, 32'h2222_2222);
        idle(1'b1); idle(1'b1);
        // Fill with EN low, then drain two per edge
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b0, 1'b0, 1'b1, 4'(i), 32'hC000_0000 + i, 1'b0, 4'd0, 32'd0);
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b0, 1'b0, 1'b1, 4'(8 + i), 32'hD000_0000 + i, 1'b1, 4'(12 + i), 32'hE000_0000 + i);
        idle(1'b1); idle(1'b1); idle(1'b1);
        // Reset with three pending
        drive_cycle(1'b0, 1'b0, 1'b1, 4'd4, 32'hF0, 1'b1, 4'd6, 32'hF1);
        drive_cycle(1'b0, 1'b0, 1'b1, 4'd8, 32'hF2, 1'b0, 4'd0, 32'd0);
        drive_cycle(1'b1, 1'b1, 1'b1, 4'd9, 32'hF3, 1'b0, 4'd0, 32'd0);
        idle(1'b1); idle(1'b1);
        // Write into an empty queue with EN high
        drive_cycle(1'b0, 1'b1, 1'b1, 4'd0, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0);
        idle(1'b1); idle(1'b1);
        // Randomised traffic with biased address collisions
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 9) < 6);
            av  = $urandom_range(0, 1) == 1;
            bv  = $urandom_range(0, 1) == 1;
            aa  = 4'($urandom_range(0, 15));
            ba  = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
            ad  = $urandom;
            bd  = $urandom;
            drive_cycle(rst, en, av, aa, ad, bv, ba, bd);
        end
        repeat (4) idle(1'b1);
        @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
